// File: rtl/axi_lite_rr_arbiter.sv
// Shares one AXI4-Lite master port between NoSlvPorts requesters; AW/AR arbitrated, W/B/R routed in order.
// Latency: zero (combinational grant and routing); one index FIFO per W, B and R holds routing order.
// Backpressure: full w/b FIFO stalls AW, full r FIFO stalls AR; AXI_LITE_RR_ARBITER_FIXED_PRIO_EN selects fixed priority.
package axi_lite_rr_arbiter_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } w_chan_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_lite_t;

   typedef struct packed {
      logic     aw_ready;
      logic     w_ready;
      b_chan_t  b;
      logic     b_valid;
      logic     ar_ready;
      r_chan_t  r;
      logic     r_valid;
   } resp_lite_t;
endpackage

// Generic synchronous FIFO.
// Latency: one cycle from push to visible head; no bypass.
// Backpressure: a push while full and a pop while empty are ignored.
module fifo #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_dat_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push, do_pop;

   assign full_o     = (cnt_q == CntW'(Depth));
   assign empty_o    = (cnt_q == '0);
   assign head_dat_o = mem[rd_ptr_q];
   assign do_push    = push_i & !full_o;
   assign do_pop     = pop_i & !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_q] <= push_dat_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

module axi_lite_rr_arbiter #(
   parameter int unsigned NoSlvPorts = 2,
   parameter int unsigned MaxTrans   = 4,
   parameter type req_lite_t  = axi_lite_rr_arbiter_pkg::req_lite_t,
   parameter type resp_lite_t = axi_lite_rr_arbiter_pkg::resp_lite_t
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  req_lite_t  slv_reqs_i  [NoSlvPorts],
   output resp_lite_t slv_resps_o [NoSlvPorts],
   output req_lite_t  mst_req_o,
   input  resp_lite_t mst_resp_i
);
   localparam int unsigned IdxW = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1;
   typedef logic [IdxW-1:0] idx_t;

   idx_t rr_aw_q, rr_ar_q, lock_aw_idx_q, lock_ar_idx_q;
   logic lock_aw_q, lock_ar_q;
   idx_t aw_sel, ar_sel, w_head, b_head, r_head;
   logic [NoSlvPorts-1:0] aw_vld_vec, ar_vld_vec;
   logic w_full, w_empty, b_full, b_empty, r_full, r_empty;
   logic aw_stall, aw_hs, ar_hs, w_hs, b_hs, r_hs, aw_pending, ar_pending;

   // First requester at or after the pointer, wrapping at NoSlvPorts-1.
   function automatic idx_t rr_pick(input logic [NoSlvPorts-1:0] vld, input idx_t start);
      idx_t        sel;
      logic        found;
      int unsigned idx;
      sel   = start;
      found = 1'b0;
      for (int unsigned i = 0; i < NoSlvPorts; i++) begin
         idx = 32'(start) + i;
         if (idx >= NoSlvPorts) idx = idx - NoSlvPorts;
         if (!found && vld[idx]) begin
            sel   = idx_t'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_comb begin
      for (int i = 0; i < NoSlvPorts; i++) begin
         aw_vld_vec[i] = slv_reqs_i[i].aw_valid;
         ar_vld_vec[i] = slv_reqs_i[i].ar_valid;
      end
      aw_sel = lock_aw_q ? lock_aw_idx_q : rr_pick(aw_vld_vec, rr_aw_q);
      ar_sel = lock_ar_q ? lock_ar_idx_q : rr_pick(ar_vld_vec, rr_ar_q);
   end

   always_comb begin
      mst_req_o = '0;
      for (int i = 0; i < NoSlvPorts; i++) begin
         slv_resps_o[i]   = '0;
         slv_resps_o[i].b = mst_resp_i.b;
         slv_resps_o[i].r = mst_resp_i.r;
      end
      aw_stall = w_full | b_full;

      mst_req_o.aw       = slv_reqs_i[aw_sel].aw;
      mst_req_o.aw_valid = slv_reqs_i[aw_sel].aw_valid & !aw_stall;
      mst_req_o.w        = slv_reqs_i[w_head].w;
      mst_req_o.w_valid  = slv_reqs_i[w_head].w_valid & !w_empty;
      mst_req_o.b_ready  = slv_reqs_i[b_head].b_ready & !b_empty;
      mst_req_o.ar       = slv_reqs_i[ar_sel].ar;
      mst_req_o.ar_valid = slv_reqs_i[ar_sel].ar_valid & !r_full;
      mst_req_o.r_ready  = slv_reqs_i[r_head].r_ready & !r_empty;

      slv_resps_o[aw_sel].aw_ready = mst_resp_i.aw_ready & !aw_stall;
      slv_resps_o[w_head].w_ready  = mst_resp_i.w_ready & !w_empty;
      slv_resps_o[b_head].b_valid  = mst_resp_i.b_valid & !b_empty;
      slv_resps_o[ar_sel].ar_ready = mst_resp_i.ar_ready & !r_full;
      slv_resps_o[r_head].r_valid  = mst_resp_i.r_valid & !r_empty;
   end

   assign aw_hs      = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign ar_hs      = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign w_hs       = mst_req_o.w_valid & mst_resp_i.w_ready;
   assign b_hs       = mst_req_o.b_ready & mst_resp_i.b_valid;
   assign r_hs       = mst_req_o.r_ready & mst_resp_i.r_valid;
   assign aw_pending = slv_reqs_i[aw_sel].aw_valid & !aw_hs;
   assign ar_pending = slv_reqs_i[ar_sel].ar_valid & !ar_hs;

   // Lock holds a pending grant so address and routing stay stable until the handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_aw_q     <= 1'b0;
         lock_aw_idx_q <= '0;
         lock_ar_q     <= 1'b0;
         lock_ar_idx_q <= '0;
      end else begin
         if (aw_hs) begin
            lock_aw_q <= 1'b0;
         end else if (aw_pending) begin
            lock_aw_q     <= 1'b1;
            lock_aw_idx_q <= aw_sel;
         end
         if (ar_hs) begin
            lock_ar_q <= 1'b0;
         end else if (ar_pending) begin
            lock_ar_q     <= 1'b1;
            lock_ar_idx_q <= ar_sel;
         end
      end
   end

`ifdef AXI_LITE_RR_ARBITER_FIXED_PRIO_EN
   assign rr_aw_q = '0;
   assign rr_ar_q = '0;
`else
   function automatic idx_t next_idx(input idx_t cur);
      return (cur == idx_t'(NoSlvPorts - 1)) ? '0 : cur + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_aw_q <= '0;
         rr_ar_q <= '0;
      end else begin
         if (aw_hs) rr_aw_q <= next_idx(aw_sel);
         if (ar_hs) rr_ar_q <= next_idx(ar_sel);
      end
   end
`endif

   fifo #(.Width(IdxW), .Depth(MaxTrans)) i_w_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(aw_hs), .push_dat_i(aw_sel),
      .pop_i(w_hs), .full_o(w_full), .empty_o(w_empty), .head_dat_o(w_head)
   );

   fifo #(.Width(IdxW), .Depth(MaxTrans)) i_b_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(aw_hs), .push_dat_i(aw_sel),
      .pop_i(b_hs), .full_o(b_full), .empty_o(b_empty), .head_dat_o(b_head)
   );

   fifo #(.Width(IdxW), .Depth(MaxTrans)) i_r_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(ar_hs), .push_dat_i(ar_sel),
      .pop_i(r_hs), .full_o(r_full), .empty_o(r_empty), .head_dat_o(r_head)
   );
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with two requesters and four outstanding transactions.
module tb_axi_lite_rr_arbiter;
   import axi_lite_rr_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   req_lite_t  slv_reqs  [2];
   resp_lite_t slv_resps [2];
   req_lite_t  mst_req;
   resp_lite_t mst_resp;
   int         checks = 0;
   int         errors = 0;
   logic [1:0] exp5 [4];
   logic [1:0] grant;

   always #5 clk = ~clk;

   axi_lite_rr_arbiter #(.NoSlvPorts(2), .MaxTrans(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .slv_reqs_i(slv_reqs), .slv_resps_o(slv_resps),
      .mst_req_o(mst_req), .mst_resp_i(mst_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_all();
      slv_reqs[0] = '0;
      slv_reqs[1] = '0;
      mst_resp    = '0;
   endtask

   // Drives every W and B response until both in-order FIFOs are empty.
   task automatic drain_wb(input string tag);
      tick();
      slv_reqs[0].w_valid = 1'b1;  slv_reqs[1].w_valid = 1'b1;
      slv_reqs[0].b_ready = 1'b1;  slv_reqs[1].b_ready = 1'b1;
      mst_resp.w_ready = 1'b1;     mst_resp.b_valid = 1'b1;
      tick();
      tick();
      #1;
      chk({tag, "_w_empty"}, mst_req.w_valid, 1'b0);
      chk({tag, "_b_empty"}, mst_req.b_ready, 1'b0);
      clear_all();
   endtask

   initial begin
`ifdef AXI_LITE_RR_ARBITER_FIXED_PRIO_EN
      exp5 = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp5 = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      rst_n = 1'b0;
      clear_all();
      slv_reqs[0].aw.addr = 32'h55;
      slv_reqs[0].b_ready = 1'b1;  slv_reqs[1].b_ready = 1'b1;
      slv_reqs[0].r_ready = 1'b1;  slv_reqs[1].r_ready = 1'b1;
      mst_resp.w_ready = 1'b1;  mst_resp.b_valid = 1'b1;  mst_resp.r_valid = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_aw_addr", mst_req.aw.addr, 32'h55);
      chk("rst_mst_w_valid", mst_req.w_valid, 1'b0);
      chk("rst_mst_b_ready", mst_req.b_ready, 1'b0);
      chk("rst_mst_r_ready", mst_req.r_ready, 1'b0);
      chk("rst_slv0_w_ready", slv_resps[0].w_ready, 1'b0);
      chk("rst_slv0_b_valid", slv_resps[0].b_valid, 1'b0);
      chk("rst_slv1_r_valid", slv_resps[1].r_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      clear_all();

      // Two simultaneous writes, then OKAY and SLVERR back in order.
      tick();
      slv_reqs[0].aw.addr = 32'h10;  slv_reqs[0].aw_valid = 1'b1;
      slv_reqs[0].w.data  = 32'hA0;  slv_reqs[0].w_valid  = 1'b1;
      slv_reqs[1].aw.addr = 32'h20;  slv_reqs[1].aw_valid = 1'b1;
      slv_reqs[1].w.data  = 32'hB0;  slv_reqs[1].w_valid  = 1'b1;
      mst_resp.aw_ready = 1'b1;  mst_resp.w_ready = 1'b1;
      #1;
      chk("t1_aw_addr0", mst_req.aw.addr, 32'h10);
      chk("t1_slv0_aw_ready", slv_resps[0].aw_ready, 1'b1);
      chk("t1_slv1_aw_ready", slv_resps[1].aw_ready, 1'b0);
      chk("t1_w_before_aw", mst_req.w_valid, 1'b0);
      tick();
      slv_reqs[0].aw_valid = 1'b0;
      #1;
      chk("t1_aw_addr1", mst_req.aw.addr, 32'h20);
      chk("t1_slv1_aw_ready2", slv_resps[1].aw_ready, 1'b1);
      chk("t1_w_data0", mst_req.w.data, 32'hA0);
      chk("t1_slv0_w_ready", slv_resps[0].w_ready, 1'b1);
      tick();
      slv_reqs[1].aw_valid = 1'b0;  slv_reqs[0].w_valid = 1'b0;
      #1;
      chk("t1_aw_idle", mst_req.aw_valid, 1'b0);
      chk("t1_w_data1", mst_req.w.data, 32'hB0);
      chk("t1_w_valid1", mst_req.w_valid, 1'b1);
      chk("t1_slv1_w_ready", slv_resps[1].w_ready, 1'b1);
      tick();
      slv_reqs[1].w_valid = 1'b0;
      slv_reqs[0].b_ready = 1'b1;  slv_reqs[1].b_ready = 1'b1;
      mst_resp.b_valid = 1'b1;  mst_resp.b.resp = 2'd0;
      #1;
      chk("t1_b0_valid", slv_resps[0].b_valid, 1'b1);
      chk("t1_b0_other", slv_resps[1].b_valid, 1'b0);
      chk("t1_b0_resp", slv_resps[0].b.resp, 2'd0);
      chk("t1_b0_ready", mst_req.b_ready, 1'b1);
      tick();
      mst_resp.b.resp = 2'd2;
      #1;
      chk("t1_b1_valid", slv_resps[1].b_valid, 1'b1);
      chk("t1_b1_other", slv_resps[0].b_valid, 1'b0);
      chk("t1_b1_resp", slv_resps[1].b.resp, 2'd2);
      tick();
      #1;
      chk("t1_b_empty_ready", mst_req.b_ready, 1'b0);
      chk("t1_b_empty_valid", slv_resps[1].b_valid, 1'b0);
      clear_all();

      // Both requesters hold AR valid; R popped alongside each new push.
      tick();
      slv_reqs[0].ar.addr = 32'h200;  slv_reqs[0].ar_valid = 1'b1;  slv_reqs[0].r_ready = 1'b1;
      slv_reqs[1].ar.addr = 32'h300;  slv_reqs[1].ar_valid = 1'b1;  slv_reqs[1].r_ready = 1'b1;
      mst_resp.ar_ready = 1'b1;  mst_resp.r_valid = 1'b1;  mst_resp.r.data = 32'h5A5A;
      for (int k = 0; k < 4; k++) begin
         #1;
         grant = slv_resps[0].ar_ready ? 2'd0 : (slv_resps[1].ar_ready ? 2'd1 : 2'd3);
         chk($sformatf("t5_grant%0d", k), grant, exp5[k]);
         if (k == 1) begin
            chk("t5_r_route", slv_resps[0].r_valid, 1'b1);
            chk("t5_r_data", slv_resps[0].r.data, 32'h5A5A);
         end
         tick();
      end
      slv_reqs[0].ar_valid = 1'b0;  slv_reqs[1].ar_valid = 1'b0;
      tick();
      #1;
      chk("t5_r_drained", mst_req.r_ready, 1'b0);
      clear_all();

      // Five reads from port 0 with no R: the fifth waits for a free slot.
      tick();
      slv_reqs[0].ar_valid = 1'b1;  slv_reqs[0].r_ready = 1'b1;
      mst_resp.ar_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         slv_reqs[0].ar.addr = 32'h100 + 32'(4 * i);
         #1;
         chk($sformatf("t3_ar_accept%0d", i), slv_resps[0].ar_ready, 1'b1);
         tick();
      end
      slv_reqs[0].ar.addr = 32'h110;
      #1;
      chk("t3_ar_full_valid", mst_req.ar_valid, 1'b0);
      chk("t3_ar_full_ready", slv_resps[0].ar_ready, 1'b0);
      tick();
      mst_resp.r_valid = 1'b1;  mst_resp.r.data = 32'h1111;
      #1;
      chk("t3_r_valid", slv_resps[0].r_valid, 1'b1);
      chk("t3_r_ready", mst_req.r_ready, 1'b1);
      chk("t3_no_bypass", mst_req.ar_valid, 1'b0);
      tick();
      mst_resp.r_valid = 1'b0;
      #1;
      chk("t3_fifth_valid", mst_req.ar_valid, 1'b1);
      chk("t3_fifth_addr", mst_req.ar.addr, 32'h110);
      tick();
      slv_reqs[0].ar_valid = 1'b0;
      mst_resp.r_valid = 1'b1;
      repeat (4) tick();
      #1;
      chk("t3_r_drained", mst_req.r_ready, 1'b0);
      clear_all();

      // Port 1 AW first, port 0 drives W early: W order must follow AW order.
      tick();
      slv_reqs[1].aw.addr = 32'h40;  slv_reqs[1].aw_valid = 1'b1;
      mst_resp.aw_ready = 1'b1;  mst_resp.w_ready = 1'b1;
      #1;
      chk("t4_aw1_ready", slv_resps[1].aw_ready, 1'b1);
      tick();
      slv_reqs[1].aw_valid = 1'b0;
      slv_reqs[0].aw.addr = 32'h30;  slv_reqs[0].aw_valid = 1'b1;
      slv_reqs[0].w.data  = 32'hC0;  slv_reqs[0].w_valid  = 1'b1;
      #1;
      chk("t4_aw0_ready", slv_resps[0].aw_ready, 1'b1);
      chk("t4_w_hold_a", mst_req.w_valid, 1'b0);
      chk("t4_w0_ready_a", slv_resps[0].w_ready, 1'b0);
      tick();
      slv_reqs[0].aw_valid = 1'b0;
      #1;
      chk("t4_w_hold_b", mst_req.w_valid, 1'b0);
      chk("t4_w0_ready_b", slv_resps[0].w_ready, 1'b0);
      tick();
      slv_reqs[1].w.data = 32'hD0;  slv_reqs[1].w_valid = 1'b1;
      #1;
      chk("t4_w1_data", mst_req.w.data, 32'hD0);
      chk("t4_w1_valid", mst_req.w_valid, 1'b1);
      chk("t4_w1_ready", slv_resps[1].w_ready, 1'b1);
      chk("t4_w0_ready_c", slv_resps[0].w_ready, 1'b0);
      tick();
      slv_reqs[1].w_valid = 1'b0;
      #1;
      chk("t4_w0_data", mst_req.w.data, 32'hC0);
      chk("t4_w0_ready_d", slv_resps[0].w_ready, 1'b1);
      tick();
      slv_reqs[0].w_valid = 1'b0;
      drain_wb("t4");

      // Stalled AW on port 0 keeps its grant when port 1 arrives.
      tick();
      slv_reqs[0].aw.addr = 32'h10;  slv_reqs[0].aw_valid = 1'b1;
      #1;
      chk("t2_addr_c1", mst_req.aw.addr, 32'h10);
      tick();
      slv_reqs[1].aw.addr = 32'h20;  slv_reqs[1].aw_valid = 1'b1;
      #1;
      chk("t2_addr_c2", mst_req.aw.addr, 32'h10);
      chk("t2_valid_c2", mst_req.aw_valid, 1'b1);
      tick();
      #1;
      chk("t2_addr_c3", mst_req.aw.addr, 32'h10);
      tick();
      mst_resp.aw_ready = 1'b1;
      #1;
      chk("t2_addr_hs", mst_req.aw.addr, 32'h10);
      chk("t2_slv0_ready", slv_resps[0].aw_ready, 1'b1);
      chk("t2_slv1_blocked", slv_resps[1].aw_ready, 1'b0);
      tick();
      slv_reqs[0].aw_valid = 1'b0;
      #1;
      chk("t2_next_addr", mst_req.aw.addr, 32'h20);
      chk("t2_slv1_ready", slv_resps[1].aw_ready, 1'b1);
      tick();
      slv_reqs[1].aw_valid = 1'b0;
      mst_resp.aw_ready = 1'b0;
      drain_wb("t2");

      // Reset with two writes outstanding discards all bookkeeping.
      tick();
      slv_reqs[0].aw.addr = 32'h80;  slv_reqs[0].aw_valid = 1'b1;
      mst_resp.aw_ready = 1'b1;
      tick();
      slv_reqs[0].aw_valid = 1'b0;
      slv_reqs[1].aw.addr = 32'h90;  slv_reqs[1].aw_valid = 1'b1;
      tick();
      clear_all();
      tick();
      rst_n = 1'b0;
      mst_resp.b_valid = 1'b1;  mst_resp.w_ready = 1'b1;
      slv_reqs[0].b_ready = 1'b1;  slv_reqs[1].b_ready = 1'b1;
      slv_reqs[0].w_valid = 1'b1;  slv_reqs[1].w_valid = 1'b1;
      #1;
      chk("t6_rst_b_ready", mst_req.b_ready, 1'b0);
      chk("t6_rst_b0_valid", slv_resps[0].b_valid, 1'b0);
      chk("t6_rst_b1_valid", slv_resps[1].b_valid, 1'b0);
      chk("t6_rst_w_valid", mst_req.w_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_post_b_ready", mst_req.b_ready, 1'b0);
      chk("t6_post_b0_valid", slv_resps[0].b_valid, 1'b0);
      chk("t6_post_w_valid", mst_req.w_valid, 1'b0);
      tick();
      slv_reqs[1].w_valid = 1'b0;
      slv_reqs[1].aw.addr = 32'h70;  slv_reqs[1].aw_valid = 1'b1;
      mst_resp.aw_ready = 1'b1;
      #1;
      chk("t6_new_aw_addr", mst_req.aw.addr, 32'h70);
      chk("t6_new_aw_ready", slv_resps[1].aw_ready, 1'b1);
      chk("t6_new_aw_other", slv_resps[0].aw_ready, 1'b0);
      tick();
      slv_reqs[1].aw_valid = 1'b0;
      #1;
      chk("t6_b1_valid", slv_resps[1].b_valid, 1'b1);
      chk("t6_b0_valid", slv_resps[0].b_valid, 1'b0);
      chk("t6_b_ready", mst_req.b_ready, 1'b1);
      chk("t6_w_head", mst_req.w_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
